mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Iterative multiply/divide sequencer that owns the HI/LO registers for the pipelined MIPS core. It executes MULT/MULTU/DIV/DIVU one bit per cycle and serves MFHI/MFLO/MTHI/MTLO. It sits beside the EX stage and raises a stall request to the hazard unit whenever EX touches HI/LO while an operation is in flight.

## Interface
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- i_CLK  in  1  clock; all state updates on rising edge.
- i_RST  in  1  synchronous, active-low reset.
- i_Start  in  1  mult/div instruction in EX; sampled only when not busy.
- i_Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_SrcA, i_SrcB  in  WIDTH  rs / rt operands from EX forwarding muxes.
- i_MfRead  in  1  MFHI/MFLO in EX.
- i_HiSel  in  1  1 selects HI, 0 selects LO for o_HiLoOut.
- i_MtHi, i_MtLo  in  1  MTHI/MTLO in EX; i_MtData written.
- i_MtData  in  WIDTH  write data for MTHI/MTLO.
- i_Abort  in  1  cancel in-flight operation (exception flush).
- o_Busy  out  1  operation in flight (RUN or FIX).
- o_StallReq  out  1  = o_Busy & (i_Start | i_MfRead | i_MtHi | i_MtLo), combinational.
- o_HiLoOut  out  WIDTH  i_HiSel ? HI : LO, combinational from registers.
- o_Done  out  1  one-cycle pulse, cycle after HI/LO update.
- o_DivByZero  out  1  one-cycle pulse coincident with o_Done on DIV/DIVU with i_SrcB=0.

## Operation
- States: IDLE, RUN, FIX. Reset: IDLE, HI=LO=0, counter=0, o_Done=0, o_DivByZero=0, o_Busy=0 (hence o_StallReq=0).
- IDLE, i_Start=1: latch op, operand signs, magnitudes (|x| for signed ops, raw for unsigned), original i_SrcA, zero-divisor flag; counter=WIDTH-1; go RUN. i_MtHi/i_MtLo in same cycle ignored (start has priority).
- IDLE, no start: i_MtHi writes HI, i_MtLo writes LO (both may fire together).
- RUN, multiply: shift-add over 2*WIDTH accumulator, one multiplier bit per edge.
- RUN, divide: restoring division, one quotient bit per edge; partial remainder WIDTH+1 bits.
- RUN: counter decrements each edge; on edge with counter==0 go FIX.
- FIX (one edge): sign-correct and commit. Signed multiply: negate 2*WIDTH product if signs differ. Signed divide: quotient negated if signs differ, remainder takes dividend sign. HI=product[2W-1:W] / remainder; LO=product[W-1:0] / quotient. Go IDLE; set o_Done=1 for next cycle.
- Divide by zero: iterations run normally (latency unchanged) but commit HI=latched original i_SrcA, LO=all ones; o_DivByZero pulses with o_Done.
- DIV of -2^(W-1) by -1: LO=0x80000000 (wraps), HI=0; no flag.
- While busy: i_Start, i_Mt*, i_MfRead have no effect other than o_StallReq; hazard unit holds EX, so request is re-presented.
- i_Abort (any state): next edge IDLE, HI/LO unchanged, no o_Done. Abort has priority over commit in FIX and over start in IDLE.
- Reset mid-operation: returns to reset values on the edge; operation discarded.

## Timing
- Start accepted at edge E0; RUN iterations at E1..E_WIDTH; FIX commit at E_WIDTH+1.
- o_Busy high for exactly WIDTH+1 cycles (33 for WIDTH=32), following E0.
- HI/LO new values visible on o_HiLoOut the cycle after E_WIDTH+1, same cycle o_Done=1; o_Busy already 0, so a stalled MFxx completes that cycle.
- Back-to-back: new i_Start accepted in the o_Done cycle.
- MTxx at edge N is readable by MFxx in cycle N+1 (no internal bypass needed).

## Test plan
- Reset: i_RST=0 two cycles with i_Start=1, i_MtHi=1 -> o_Busy=0, HI=LO=0, o_Done never pulses.
- MULT 0xFFFFFFFE x 0x00000003 -> o_Busy high exactly 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, o_Done one cycle; MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 2 -> LO=3, HI=1; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MFLO asserted 5 cycles after start -> o_StallReq=1 each busy cycle, 0 in o_Done cycle with o_HiLoOut = new LO.
- DIVU 0x00001234 / 0 -> after 34 edges HI=0x00001234, LO=0xFFFFFFFF, o_DivByZero and o_Done pulse together.
- MTHI 0xA5A5A5A5, then MULT, i_Abort at 10th RUN cycle -> o_Busy 0 next cycle, HI=0xA5A5A5A5, LO unchanged, no o_Done; new start accepted immediately after.

Source files
------------

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, one bit per cycle.
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_Start,
    input  logic [1:0]       i_Op,
    input  logic [WIDTH-1:0] i_SrcA,
    input  logic [WIDTH-1:0] i_SrcB,
    input  logic             i_MfRead,
    input  logic             i_HiSel,
    input  logic             i_MtHi,
    input  logic             i_MtLo,
    input  logic [WIDTH-1:0] i_MtData,
    input  logic             i_Abort,
    output logic             o_Busy,
    output logic             o_StallReq,
    output logic [WIDTH-1:0] o_HiLoOut,
    output logic             o_Done,
    output logic             o_DivByZero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic sa_q, sa_d, sb_q, sb_d, dz_q, dz_d, done_q, done_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod;
    logic [WIDTH-1:0] mag_a, mag_b, rem_n, quo, rem;
    logic [WIDTH:0] sum, shl;
    logic sgn_in, ge;
    assign sgn_in = ~i_Op[0];
    assign mag_a = (sgn_in && i_SrcA[WIDTH-1]) ? -i_SrcA : i_SrcA;
    assign mag_b = (sgn_in && i_SrcB[WIDTH-1]) ? -i_SrcB : i_SrcB;
    // Multiply: acc = {partial product high, remaining multiplier bits}
    assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
    // Divide: acc = {partial remainder, dividend bits becoming quotient}; remainder < divisor fits WIDTH bits
    assign shl = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign ge = shl >= {1'b0, b_q};
    assign rem_n = ge ? shl[WIDTH-1:0] - b_q : shl[WIDTH-1:0];
    assign prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        op_d = op_q;
        sa_d = sa_q;
        sb_d = sb_q;
        dz_d = dz_q;
        a_d = a_q;
        b_d = b_q;
        acc_d = acc_q;
        hi_d = hi_q;
        lo_d = lo_q;
        done_d = 1'b0;
        dbz_d = 1'b0;
        if (i_Abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_Start) begin
                        state_d = RUN;
                        cnt_d = CW'(WIDTH - 1);
                        op_d = i_Op;
                        sa_d = sgn_in & i_SrcA[WIDTH-1];
                        sb_d = sgn_in & i_SrcB[WIDTH-1];
                        dz_d = ~|i_SrcB;
                        a_d = i_SrcA;
                        b_d = mag_b;
                        acc_d = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        hi_d = i_MtHi ? i_MtData : hi_q;
                        lo_d = i_MtLo ? i_MtData : lo_q;
                    end
                end
                RUN: begin
                    acc_d = op_q[1] ? {rem_n, acc_q[WIDTH-2:0], ge} : {sum, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q - 1'b1;
                    state_d = (cnt_q == '0) ? FIX : RUN;
                end
                FIX: begin
                    state_d = IDLE;
                    done_d = 1'b1;
                    dbz_d = op_q[1] & dz_q;
                    hi_d = !op_q[1] ? prod[2*WIDTH-1:WIDTH] : dz_q ? a_q : rem;
                    lo_d = !op_q[1] ? prod[WIDTH-1:0] : dz_q ? {WIDTH{1'b1}} : quo;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            state_q <= IDLE;
            cnt_q <= '0;
            op_q <= '0;
            sa_q <= 1'b0;
            sb_q <= 1'b0;
            dz_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            acc_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            done_q <= 1'b0;
            dbz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            op_q <= op_d;
            sa_q <= sa_d;
            sb_q <= sb_d;
            dz_q <= dz_d;
            a_q <= a_d;
            b_q <= b_d;
            acc_q <= acc_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            done_q <= done_d;
            dbz_q <= dbz_d;
        end
    end
    assign o_Busy = state_q != IDLE;
    assign o_StallReq = o_Busy & (i_Start | i_MfRead | i_MtHi | i_MtLo);
    assign o_HiLoOut = i_HiSel ? hi_q : lo_q;
    assign o_Done = done_q;
    assign o_DivByZero = dbz_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed vectors for the multiply/divide sequencer.
module tb_mdu_sequencer;
    logic clk = 1'b0;
    logic rst_n, start, mf_read, hi_sel, mt_hi, mt_lo, abort_op;
    logic [1:0] op;
    logic [31:0] src_a, src_b, mt_data;
    logic busy, stall, done, dbz;
    logic [31:0] hilo;
    int vectors = 0;
    int errors = 0;
    always #5 clk = ~clk;
    mdu_sequencer #(.WIDTH(32)) dut (
        .i_CLK(clk), .i_RST(rst_n), .i_Start(start), .i_Op(op),
        .i_SrcA(src_a), .i_SrcB(src_b), .i_MfRead(mf_read), .i_HiSel(hi_sel),
        .i_MtHi(mt_hi), .i_MtLo(mt_lo), .i_MtData(mt_data), .i_Abort(abort_op),
        .o_Busy(busy), .o_StallReq(stall), .o_HiLoOut(hilo),
        .o_Done(done), .o_DivByZero(dbz)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        hi_sel = 1'b1;
        #1 hi = hilo;
        hi_sel = 1'b0;
        #1 lo = hilo;
    endtask
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int nbusy, output logic d, output logic z,
                         output logic [31:0] hi, output logic [31:0] lo);
        start = 1'b1; op = o; src_a = a; src_b = b;
        step();
        start = 1'b0;
        nbusy = 0;
        while (busy && nbusy < 100) begin
            nbusy++;
            step();
        end
        d = done;
        z = dbz;
        read_hilo(hi, lo);
    endtask
    task automatic test_reset();
        logic [31:0] hi, lo;
        rst_n = 1'b0; start = 1'b1; mt_hi = 1'b1; mt_data = 32'h1234_5678; op = 2'b00;
        src_a = 32'd5; src_b = 32'd3;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl cyc%0d: busy=%b done=%b stall=%b, want 0/0/0", i, busy, done, stall);
            end
        end
        read_hilo(hi, lo);
        vectors++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo: hi=%h lo=%h, want 0/0", hi, lo);
        end
        rst_n = 1'b1; start = 1'b0; mt_hi = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b, want 0/0", busy, done);
        end
    endtask
    task automatic test_mult();
        int n; logic d, z; logic [31:0] hi, lo;
        do_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, n, d, z, hi, lo);
        vectors++;
        if (n !== 33 || d !== 1'b1 || z !== 1'b0) begin
            errors++;
            $display("FAIL mult_timing: busy=%0d done=%b dbz=%b, want 33/1/0", n, d, z);
        end
        vectors++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mult_result: hi=%h lo=%h, want ffffffff/fffffffa", hi, lo);
        end
        step();
        vectors++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL mult_done_pulse: done=%b a cycle later, want 0", done);
        end
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, d, z, hi, lo);
        vectors++;
        if (n !== 33 || d !== 1'b1 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu: busy=%0d done=%b hi=%h lo=%h, want 33/1/fffffffe/00000001", n, d, hi, lo);
        end
    endtask
    task automatic test_div();
        int n; logic d, z; logic [31:0] hi, lo;
        do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, n, d, z, hi, lo);
        vectors++;
        if (n !== 33 || d !== 1'b1 || z !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_neg: busy=%0d done=%b dbz=%b hi=%h lo=%h, want 33/1/0/ffffffff/fffffffd", n, d, z, hi, lo);
        end
        do_op(2'b11, 32'd7, 32'd2, n, d, z, hi, lo);
        vectors++;
        if (d !== 1'b1 || hi !== 32'd1 || lo !== 32'd3) begin
            errors++;
            $display("FAIL divu_7_2: done=%b hi=%h lo=%h, want 1/1/3", d, hi, lo);
        end
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n, d, z, hi, lo);
        vectors++;
        if (d !== 1'b1 || z !== 1'b0 || hi !== 32'h0 || lo !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_min_m1: done=%b dbz=%b hi=%h lo=%h, want 1/0/0/80000000", d, z, hi, lo);
        end
        do_op(2'b10, 32'd100, 32'hFFFF_FFF9, n, d, z, hi, lo);
        vectors++;
        if (hi !== 32'd2 || lo !== 32'hFFFF_FFF2) begin
            errors++;
            $display("FAIL div_100_m7: hi=%h lo=%h, want 00000002/fffffff2", hi, lo);
        end
    endtask
    task automatic test_stall();
        int n = 0; int bad = 0;
        start = 1'b1; op = 2'b01; src_a = 32'd6; src_b = 32'd7;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        mf_read = 1'b1; hi_sel = 1'b0;
        #1;
        while (busy && n < 100) begin
            if (stall !== 1'b1) bad++;
            n++;
            step();
        end
        vectors++;
        if (bad != 0 || n != 29) begin
            errors++;
            $display("FAIL stall_busy: %0d low-stall cycles over %0d, want 0 over 29", bad, n);
        end
        vectors++;
        if (stall !== 1'b0 || done !== 1'b1 || hilo !== 32'd42) begin
            errors++;
            $display("FAIL stall_release: stall=%b done=%b out=%h, want 0/1/0000002a", stall, done, hilo);
        end
        mf_read = 1'b0;
    endtask
    task automatic test_divzero();
        int n; logic d, z; logic [31:0] hi, lo;
        do_op(2'b11, 32'h0000_1234, 32'h0, n, d, z, hi, lo);
        vectors++;
        if (n !== 33 || d !== 1'b1 || z !== 1'b1) begin
            errors++;
            $display("FAIL divzero_flags: busy=%0d done=%b dbz=%b, want 33/1/1", n, d, z);
        end
        vectors++;
        if (hi !== 32'h0000_1234 || lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL divzero_result: hi=%h lo=%h, want 00001234/ffffffff", hi, lo);
        end
        step();
        vectors++;
        if (dbz !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL divzero_pulse: dbz=%b done=%b, want 0/0", dbz, done);
        end
    endtask
    task automatic test_mt();
        logic [31:0] hi, lo;
        mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'h0BAD_F00D;
        step();
        mt_hi = 1'b0; mt_lo = 1'b0;
        read_hilo(hi, lo);
        vectors++;
        if (hi !== 32'h0BAD_F00D || lo !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL mt_both: hi=%h lo=%h, want 0badf00d/0badf00d", hi, lo);
        end
        mt_lo = 1'b1; mt_data = 32'h1111_2222;
        step();
        mt_lo = 1'b0;
        read_hilo(hi, lo);
        vectors++;
        if (hi !== 32'h0BAD_F00D || lo !== 32'h1111_2222) begin
            errors++;
            $display("FAIL mt_lo_only: hi=%h lo=%h, want 0badf00d/11112222", hi, lo);
        end
    endtask
    task automatic test_abort();
        int n; logic d, z; logic [31:0] hi, lo;
        mt_hi = 1'b1; mt_data = 32'hA5A5_A5A5;
        step();
        mt_hi = 1'b0;
        start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd5;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        abort_op = 1'b1;
        step();
        abort_op = 1'b0;
        read_hilo(hi, lo);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hA5A5_A5A5 || lo !== 32'h1111_2222) begin
            errors++;
            $display("FAIL abort: busy=%b done=%b hi=%h lo=%h, want 0/0/a5a5a5a5/11112222", busy, done, hi, lo);
        end
        do_op(2'b01, 32'd3, 32'd5, n, d, z, hi, lo);
        vectors++;
        if (n !== 33 || d !== 1'b1 || hi !== 32'd0 || lo !== 32'd15) begin
            errors++;
            $display("FAIL abort_restart: busy=%0d done=%b hi=%h lo=%h, want 33/1/0/f", n, d, hi, lo);
        end
    endtask
    task automatic test_back_to_back();
        int n; logic d, z; logic [31:0] hi, lo;
        do_op(2'b11, 32'd100, 32'd9, n, d, z, hi, lo);
        vectors++;
        if (hi !== 32'd1 || lo !== 32'd11) begin
            errors++;
            $display("FAIL b2b_first: hi=%h lo=%h, want 1/b", hi, lo);
        end
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, d, z, hi, lo);
        vectors++;
        if (n !== 33 || d !== 1'b1 || hi !== 32'd0 || lo !== 32'd1) begin
            errors++;
            $display("FAIL b2b_second: busy=%0d done=%b hi=%h lo=%h, want 33/1/0/1", n, d, hi, lo);
        end
    endtask
    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        mf_read = 1'b0; hi_sel = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0; abort_op = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_divzero();
        test_mt();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
